// File: rtl/reg_bank_arbiter.sv
// Round-robin shared 1-bit flag bank: one granted single-bit read/write per 2 cycles.
// Latency: req->gnt 1 cycle, write commit / rvalid 2 cycles; requesters wait on gnt (level req).
module reg_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ-1:0]      wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 rdata,
    output logic                 rvalid,
    output logic                 busy,
    output logic [NREGS-1:0]     regs_q
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [NREGS-1:0]  regs_d;

    logic              win_vld;
    logic [LW-1:0]     win_idx;
    logic              cur_we;
    logic              cur_wdata;
    logic [AW-1:0]     cur_addr;
    logic              addr_ok;

    // Search starts just after the previous winner so every requester is served in turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_vld && req[(int'(last_q) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_idx = LW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // In GRANT, last_q is the index of the requester currently holding gnt.
    always_comb begin
        cur_we    = we[last_q];
        cur_wdata = wdata[last_q];
        cur_addr  = addr[int'(last_q)*AW +: AW];
        addr_ok   = (int'(cur_addr) < NREGS);
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = '0;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        regs_d   = regs_q;
        case (state_q)
            IDLE, RESP: begin
                if (win_vld) begin
                    gnt_d[win_idx] = 1'b1;
                    last_d         = win_idx;
                    state_d        = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (cur_we) begin
                    if (addr_ok) begin
                        regs_d[cur_addr] = cur_wdata;
                    end
                end else begin
                    rdata_d  = addr_ok ? regs_q[cur_addr] : 1'b0;
                    rvalid_d = 1'b1;
                end
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= LW'(NREQ - 1);
            gnt_q    <= '0;
            rdata_q  <= 1'b0;
            rvalid_q <= 1'b0;
            regs_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            regs_q   <= regs_d;
        end
    end

    assign gnt    = gnt_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (NREQ=4, NREGS=6, AW=3).
module tb_reg_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [3:0]  wdata;
    logic [3:0]  gnt;
    logic        rdata;
    logic        rvalid;
    logic        busy;
    logic [5:0]  regs_q;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    reg_bank_arbiter #(.NREQ(4), .NREGS(6), .AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy),
        .regs_q (regs_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt [0:7];
        exp_gnt[0] = 4'b0000; exp_gnt[1] = 4'b0010;
        exp_gnt[2] = 4'b0000; exp_gnt[3] = 4'b0100;
        exp_gnt[4] = 4'b0000; exp_gnt[5] = 4'b1000;
        exp_gnt[6] = 4'b0000; exp_gnt[7] = 4'b0001;

        rst = 1'b1; req = 4'b1111; we = 4'b0000; addr = '0; wdata = 4'b0000;

        // Reset held two cycles with every requester active
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_gnt",    32'(gnt),    32'h0);
            chk("rst_rvalid", 32'(rvalid), 32'h0);
            chk("rst_busy",   32'(busy),   32'h0);
            chk("rst_regs",   32'(regs_q), 32'h0);
        end
        rst = 1'b0;

        // Fairness: all four reading continuously
        step();
        chk("rr_first_gnt", 32'(gnt),  32'h1);
        chk("rr_first_busy", 32'(busy), 32'h1);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_gnt",  32'(gnt),  32'(exp_gnt[c]));
            chk("rr_busy", 32'(busy), 32'h1);
        end
        step();
        chk("rr_resp_gnt",    32'(gnt),    32'h0);
        chk("rr_resp_rvalid", 32'(rvalid), 32'h1);
        req = 4'b0000;
        step();
        chk("rr_idle_busy", 32'(busy), 32'h0);

        // Reset during a write grant: nothing committed
        req = 4'b1000; we = 4'b1000; addr[9 +: 3] = 3'd3; wdata = 4'b1000;
        step();
        chk("rstw_gnt", 32'(gnt), 32'h8);
        rst = 1'b1; req = 4'b0000;
        step();
        chk("rstw_regs",   32'(regs_q), 32'h0);
        chk("rstw_gnt0",   32'(gnt),    32'h0);
        chk("rstw_rvalid", 32'(rvalid), 32'h0);
        chk("rstw_busy",   32'(busy),   32'h0);
        rst = 1'b0; we = 4'b0000; wdata = 4'b0000; addr = '0;

        // Write 1 to register 5 from requester 2
        req = 4'b0100; we = 4'b0100; addr[6 +: 3] = 3'd5; wdata = 4'b0100;
        step();
        chk("wr_gnt",  32'(gnt),    32'h4);
        chk("wr_regs_early", 32'(regs_q), 32'h0);
        step();
        chk("wr_regs",   32'(regs_q), 32'h20);
        chk("wr_rvalid", 32'(rvalid), 32'h0);
        chk("wr_gnt0",   32'(gnt),    32'h0);
        req = 4'b0000; we = 4'b0000; wdata = 4'b0000;
        step();
        chk("wr_idle", 32'(busy), 32'h0);

        // Read register 5 back from requester 1
        req = 4'b0010; addr[3 +: 3] = 3'd5;
        step();
        chk("rd_gnt",    32'(gnt),    32'h2);
        chk("rd_rv_early", 32'(rvalid), 32'h0);
        step();
        chk("rd_rvalid", 32'(rvalid), 32'h1);
        chk("rd_rdata",  32'(rdata),  32'h1);
        req = 4'b0000;
        step();
        chk("rd_rvalid_drop", 32'(rvalid), 32'h0);
        chk("rd_rdata_hold",  32'(rdata),  32'h1);

        // Back-to-back: requester 3 writes reg 0, then requester 0 reads it
        addr = '0;
        req = 4'b1001; we = 4'b1000; wdata = 4'b1000;
        step();
        chk("b2b_gnt3", 32'(gnt), 32'h8);
        step();
        chk("b2b_regs", 32'(regs_q), 32'h21);
        chk("b2b_resp_gnt", 32'(gnt), 32'h0);
        req = 4'b0001; we = 4'b0000; wdata = 4'b0000;
        step();
        chk("b2b_gnt0", 32'(gnt),  32'h1);
        chk("b2b_busy", 32'(busy), 32'h1);
        step();
        chk("b2b_rvalid", 32'(rvalid), 32'h1);
        chk("b2b_rdata",  32'(rdata),  32'h1);
        req = 4'b0000;
        step();
        chk("b2b_idle", 32'(busy), 32'h0);

        // Out of range address 7 (NREGS=6): write ignored, read returns 0
        req = 4'b0001; we = 4'b0001; addr[0 +: 3] = 3'd7; wdata = 4'b0001;
        step();
        chk("oor_wgnt", 32'(gnt), 32'h1);
        step();
        chk("oor_wregs",   32'(regs_q), 32'h21);
        chk("oor_wrvalid", 32'(rvalid), 32'h0);
        we = 4'b0000; wdata = 4'b0000;
        step();
        chk("oor_rgnt", 32'(gnt), 32'h1);
        step();
        chk("oor_rvalid", 32'(rvalid), 32'h1);
        chk("oor_rdata",  32'(rdata),  32'h0);
        req = 4'b0000;
        step();
        chk("oor_rvalid_drop", 32'(rvalid), 32'h0);
        chk("oor_busy",        32'(busy),   32'h0);
        chk("oor_regs_final",  32'(regs_q), 32'h21);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
